interleaver_seq_ctrl: RTL and testbench

Sequencing controller for the 4x4 byte block interleaver. It accepts a byte stream over a valid/ready handshake and writes each 16-byte block into the interleaver in row order. It then drains the block by issuing the 16 interleaved reads, and presents the result as a framed valid/ready output stream. It sits between the upstream byte source and the downstream consumer, and owns the interleaver's write_i, leaver_i, addr and data_i pins.

---
 rtl/interleaver_seq_ctrl_pkg.sv | 15 +
 rtl/interleaver_skid_fifo.sv | 75 +++++++
 rtl/interleaver_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_interleaver_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_seq_ctrl_pkg.sv
// Shared types and constants for the 4x4 block interleaver sequencing controller.
// il_addr_map gives the memory byte read for output position k.
package interleaver_seq_ctrl_pkg;

  typedef enum logic {StFill, StDrain} state_e;

  localparam int unsigned BLK    = 16;
  localparam int unsigned ADDR_W = 4;

  // Output k reads memory byte (k % 4) * 4 + k / 4.
  function automatic logic [ADDR_W-1:0] il_addr_map(input logic [ADDR_W-1:0] k);
    return {k[1:0], k[3:2]};
  endfunction

endpackage

// File: rtl/interleaver_skid_fifo.sv
// Small FIFO of {sof, eof, data} entries that absorbs the interleaver read latency.
// Supports a same-cycle push and pop, plus a synchronous clear.
module interleaver_skid_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when a pop frees the head slot.
  assign wr_en = push_i && (!full_o || pop_i) && !clear_i;
  assign rd_en = pop_i && !empty_o && !clear_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/interleaver_seq_ctrl.sv
// Fills the 4x4 interleaver in row order, then drains it with interleaved reads
// into a framed valid/ready output stream; fill and drain never overlap.
module interleaver_seq_ctrl
  import interleaver_seq_ctrl_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned SKID = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof,
  input  logic          flush,
  output logic          il_write,
  output logic          il_leaver,
  output logic [3:0]    il_addr,
  output logic [DW-1:0] il_wdata,
  input  logic [DW-1:0] il_rdata,
  output logic [15:0]   blk_cnt,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(SKID + 1);

  state_e       state_q, state_d;
  logic [3:0]   wr_cnt_q, wr_cnt_d;
  logic [4:0]   rd_cnt_q, rd_cnt_d;
  logic         inflight_q, inflight_d;
  logic [3:0]   inflight_tag_q, inflight_tag_d;
  logic [15:0]  blk_cnt_q, blk_cnt_d;
  logic         flush_hold_q, flush_hold_d;

  logic            in_fire, out_fire;
  logic            fifo_push, fifo_clear, fifo_full, fifo_empty;
  logic [DW+1:0]   fifo_wdata, fifo_head;
  logic [CntW-1:0] fifo_cnt;
  logic [3:0]      credit;

  interleaver_skid_fifo #(
    .Width (DW + 2),
    .Depth (SKID)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (out_fire),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_valid = !fifo_empty;
  assign out_sof   = out_valid && fifo_head[DW+1];
  assign out_eof   = out_valid && fifo_head[DW];
  assign out_data  = fifo_head[DW-1:0];
  assign out_fire  = out_valid && out_ready;
  assign blk_cnt   = blk_cnt_q;
  assign busy      = (state_q != StFill) || (wr_cnt_q != '0);

  assign in_ready = rst && (state_q == StFill) && !flush_hold_q;
  assign in_fire  = in_valid && in_ready;

  // Slots committed to the skid once this cycle's pop and the in-flight read land.
  assign credit = 4'(fifo_cnt) + 4'(inflight_q) - 4'(out_fire);

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    inflight_d     = 1'b0;
    inflight_tag_d = inflight_tag_q;
    blk_cnt_d      = blk_cnt_q;
    flush_hold_d   = flush;
    il_write       = 1'b0;
    il_leaver      = 1'b0;
    il_addr        = '0;
    il_wdata       = '0;
    fifo_clear     = 1'b0;
    fifo_push      = inflight_q;
    fifo_wdata     = {(inflight_tag_q == 4'd0), (inflight_tag_q == 4'(BLK - 1)), il_rdata};

    unique case (state_q)
      StFill: begin
        if (in_fire && !flush) begin
          il_write = 1'b1;
          il_addr  = wr_cnt_q;
          il_wdata = in_data;
          if (wr_cnt_q == 4'(BLK - 1)) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = StDrain;
          end else begin
            wr_cnt_d = wr_cnt_q + 4'd1;
          end
        end
      end
      StDrain: begin
        if ((rd_cnt_q < 5'(BLK)) && (credit < 4'(SKID)) && (!fifo_full || out_fire)) begin
          il_leaver      = 1'b1;
          il_addr        = rd_cnt_q[3:0];
          inflight_d     = 1'b1;
          inflight_tag_d = rd_cnt_q[3:0];
          rd_cnt_d       = rd_cnt_q + 5'd1;
        end
        if (out_fire && fifo_head[DW]) begin
          state_d   = StFill;
          rd_cnt_d  = '0;
          blk_cnt_d = blk_cnt_q + 16'd1;
        end
      end
      default: state_d = StFill;
    endcase

    if (flush) begin
      state_d    = StFill;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      inflight_d = 1'b0;
      blk_cnt_d  = blk_cnt_q;
      fifo_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StFill;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      blk_cnt_q      <= '0;
      flush_hold_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      blk_cnt_q      <= blk_cnt_d;
      flush_hold_q   <= flush_hold_d;
    end
  end

endmodule

// File: tb/tb_interleaver_seq_ctrl.sv
// Directed bench for interleaver_seq_ctrl with a behavioural 4x4 interleaver memory
// (registered read) and an output monitor recording every accepted byte.
module tb_interleaver_seq_ctrl;
  import interleaver_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_sof, out_eof, flush;
  logic        il_write, il_leaver, busy;
  logic [7:0]  in_data, out_data, il_wdata, il_rdata;
  logic [3:0]  il_addr;
  logic [15:0] blk_cnt;

  interleaver_seq_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .flush     (flush),
    .il_write  (il_write),
    .il_leaver (il_leaver),
    .il_addr   (il_addr),
    .il_wdata  (il_wdata),
    .il_rdata  (il_rdata),
    .blk_cnt   (blk_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Interleaver memory: row-order writes, interleaved registered reads.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (il_write) mem[il_addr] <= il_wdata;
    if (il_leaver) il_rdata <= mem[il_addr_map(il_addr)];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and protocol watchers, sampled mid-cycle.
  logic [9:0] obs_v [256];
  int         obs_t [256];
  int         obs_n = 0;
  int         excl_viol = 0, rdy_viol = 0, lv_total = 0;
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && obs_n < 256) begin
      obs_v[obs_n] = {out_sof, out_eof, out_data};
      obs_t[obs_n] = cyc;
      obs_n = obs_n + 1;
    end
    if (il_write && il_leaver) excl_viol = excl_viol + 1;
    if (in_ready && il_leaver) rdy_viol = rdy_viol + 1;
    if (il_leaver) lv_total = lv_total + 1;
  end

  logic [3:0] perm [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                            4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};

  int n_checks = 0;
  int n_errs   = 0;
  int rd_idx   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(base + 8'(i));
    end
  endtask

  task automatic wait_out(input int target);
    int t = 0;
    while (obs_n < target && t < 600) begin
      tick();
      t++;
    end
    if (obs_n < target) check_eq("out_timeout", 32'(obs_n), 32'(target));
  endtask

  task automatic check_block(input logic [7:0] base, output int t0, output int t15);
    logic [9:0] e;
    t0  = obs_t[rd_idx];
    t15 = obs_t[rd_idx + 15];
    for (int k = 0; k < 16; k++) begin
      e = {(k == 0), (k == 15), 8'(base + 8'(perm[k]))};
      check_eq($sformatf("blk%02h_k%0d", base, k), 32'(obs_v[rd_idx]), 32'(e));
      rd_idx++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, 32'({in_ready, out_valid, out_sof, out_eof, il_write, il_leaver,
                       il_addr, il_wdata, busy}), 32'd0);
    check_eq({tag, "_blk"}, 32'(blk_cnt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  t0, t15, lv_base, unstable, n_base;
    bit  t2_done;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    // Back-to-back block, latency and throughput
    send_block(8'h00, 1'b0);
    @(negedge clk); check_eq("lat_c0", 32'(out_valid), 32'd0);
    @(negedge clk); check_eq("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk); check_eq("lat_c2", 32'(out_valid), 32'd1);
    tick();
    wait_out(rd_idx + 16);
    check_block(8'h00, t0, t15);
    check_eq("thru_b1", 32'(t15 - t0), 32'd15);
    check_eq("blk_cnt_1", 32'(blk_cnt), 32'd1);

    // Input gaps with random output backpressure
    t2_done = 1'b0;
    fork
      begin
        send_block(8'h10, 1'b1);
        wait_out(rd_idx + 16);
        t2_done = 1'b1;
      end
      begin
        while (!t2_done) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    check_block(8'h10, t0, t15);
    check_eq("blk_cnt_2", 32'(blk_cnt), 32'd2);

    // Output held off at start of drain
    out_ready = 1'b0;
    lv_base   = lv_total;
    unstable  = 0;
    send_block(8'h00, 1'b0);
    repeat (10) begin
      @(negedge clk);
      if (out_valid && out_data != 8'h00) unstable++;
    end
    check_eq("hold_reads", 32'(lv_total - lv_base), 32'd2);
    check_eq("hold_valid", 32'(out_valid), 32'd1);
    check_eq("hold_data", 32'(out_data), 32'h00);
    check_eq("hold_stable", 32'(unstable), 32'd0);
    tick();
    out_ready = 1'b1;
    wait_out(rd_idx + 16);
    check_block(8'h00, t0, t15);
    check_eq("thru_release", 32'(t15 - t0), 32'd15);
    check_eq("blk_cnt_3", 32'(blk_cnt), 32'd3);

    // Flush after 7 bytes
    n_base = obs_n;
    for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i));
    @(negedge clk);
    check_eq("busy_pre_flush", 32'(busy), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("flush_in_ready_next", 32'(in_ready), 32'd1);
    check_eq("flush_no_out", 32'(obs_n), 32'(n_base));
    check_eq("flush_blk_cnt", 32'(blk_cnt), 32'd3);
    tick();
    send_block(8'h20, 1'b0);
    wait_out(rd_idx + 16);
    check_block(8'h20, t0, t15);
    check_eq("blk_cnt_4", 32'(blk_cnt), 32'd4);

    // Reset mid-drain after 5 outputs
    send_block(8'h30, 1'b0);
    wait_out(rd_idx + 5);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    tick();
    rst   = 1'b1;
    rd_idx = obs_n;

    // Three consecutive blocks
    send_block(8'hA0, 1'b0);
    send_block(8'hB0, 1'b0);
    send_block(8'hC0, 1'b0);
    wait_out(rd_idx + 48);
    check_block(8'hA0, t0, t15);
    check_block(8'hB0, t0, t15);
    check_block(8'hC0, t0, t15);
    check_eq("blk_cnt_3blk", 32'(blk_cnt), 32'd3);

    check_eq("write_leaver_excl", 32'(excl_viol), 32'd0);
    check_eq("in_ready_in_drain", 32'(rdy_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
